// File: rtl/game_screen_ctrl.sv
// Game flow screen sequencer: picks the active screen's rgb, decodes select codes, and blanks on every screen change.
// Optional build macro STAGE_TIMER_EN adds a per-stage frame timer that kills the player when it runs out.
module game_screen_ctrl #(
  parameter int BLANK_FRAMES = 2,
  parameter int STAGE_FRAMES = 3600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [4:0]  key_pulse,
  input  logic [1:0]  menu_sel,
  input  logic [1:0]  die1_sel,
  input  logic [1:0]  die2_sel,
  input  logic        dead1,
  input  logic        dead2,
  input  logic        clr1,
  input  logic        clr2,
  input  logic [2:0]  rgb_title,
  input  logic [2:0]  rgb_s1,
  input  logic [2:0]  rgb_d1,
  input  logic [2:0]  rgb_s2,
  input  logic [2:0]  rgb_d2,
  input  logic [2:0]  rgb_clr,
  output logic [2:0]  rgb,
  output logic [2:0]  screen,
  output logic [4:0]  key_out,
  output logic        stage_rst,
  output logic [11:0] time_left
);

  typedef enum logic [2:0] {TITLE = 3'd0, S1 = 3'd1, D1 = 3'd2, S2 = 3'd3, D2 = 3'd4, CLR = 3'd5} screen_t;

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_FRAMES);

  screen_t    screen_q, screen_d, target_q, target_d, dest;
  logic       blanking_q, blanking_d;
  logic [3:0] blank_cnt_q, blank_cnt_d;
  logic       stage_rst_q, stage_rst_d;
  logic       origin_q, origin_d;
  logic       at_origin, frame_tick, trig, timer_dead, scr_bad, blank_done;
  logic [2:0] rgb_sel;

  assign at_origin  = (x == 10'd0) && (y == 10'd0);
  assign frame_tick = at_origin && !origin_q;
  assign scr_bad    = (screen_q > CLR);
  assign blank_done = blanking_q && frame_tick && (blank_cnt_q <= 4'd1);

`ifdef STAGE_TIMER_EN
  localparam logic [11:0] TIMER_INIT = 12'(STAGE_FRAMES);
  logic [11:0] timer_q, timer_d;
  logic        in_stage;

  assign in_stage   = (screen_q == S1) || (screen_q == S2);
  assign timer_dead = !blanking_q && in_stage && frame_tick && (timer_q == 12'd1);
  assign time_left  = timer_q;

  always_comb begin
    timer_d = timer_q;
    if (blank_done && ((target_q == S1) || (target_q == S2)))
      timer_d = TIMER_INIT;
    else if (!blanking_q && in_stage && frame_tick && (timer_q != 12'd0))
      timer_d = timer_q - 12'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= TIMER_INIT;
    else     timer_q <= timer_d;
  end
`else
  assign timer_dead = 1'b0;
  assign time_left  = 12'd0;
`endif

  always_comb begin
    trig = 1'b0;
    dest = screen_q;
    if (!blanking_q) begin
      case (screen_q)
        TITLE: if (menu_sel == 2'b00) begin trig = 1'b1; dest = S1; end
        S1: begin
          if (dead1 || timer_dead) begin trig = 1'b1; dest = D1; end
          else if (clr1)           begin trig = 1'b1; dest = S2; end
        end
        D1: begin
          if (die1_sel == 2'b00)      begin trig = 1'b1; dest = S1; end
          else if (die1_sel == 2'b01) begin trig = 1'b1; dest = TITLE; end
        end
        S2: begin
          if (dead2 || timer_dead) begin trig = 1'b1; dest = D2; end
          else if (clr2)           begin trig = 1'b1; dest = CLR; end
        end
        D2: begin
          if (die2_sel == 2'b00)      begin trig = 1'b1; dest = S2; end
          else if (die2_sel == 2'b01) begin trig = 1'b1; dest = TITLE; end
        end
        CLR: if (key_pulse == 5'h1d) begin trig = 1'b1; dest = TITLE; end
        default: ;
      endcase
    end
  end

  always_comb begin
    screen_d    = screen_q;
    target_d    = target_q;
    blanking_d  = blanking_q;
    blank_cnt_d = blank_cnt_q;
    stage_rst_d = stage_rst_q;
    origin_d    = at_origin;
    if (scr_bad) begin
      // Corrupted screen code: recover straight to the title without blanking.
      screen_d    = TITLE;
      blanking_d  = 1'b0;
      blank_cnt_d = 4'd0;
      stage_rst_d = 1'b0;
    end else if (blanking_q) begin
      if (blank_done) begin
        screen_d    = target_q;
        blanking_d  = 1'b0;
        blank_cnt_d = 4'd0;
        stage_rst_d = 1'b0;
      end else if (frame_tick) begin
        blank_cnt_d = blank_cnt_q - 4'd1;
      end
    end else if (trig) begin
      target_d    = dest;
      blanking_d  = 1'b1;
      blank_cnt_d = BLANK_INIT;
      stage_rst_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      screen_q    <= TITLE;
      target_q    <= TITLE;
      blanking_q  <= 1'b0;
      blank_cnt_q <= 4'd0;
      stage_rst_q <= 1'b0;
      origin_q    <= 1'b0;
    end else begin
      screen_q    <= screen_d;
      target_q    <= target_d;
      blanking_q  <= blanking_d;
      blank_cnt_q <= blank_cnt_d;
      stage_rst_q <= stage_rst_d;
      origin_q    <= origin_d;
    end
  end

  always_comb begin
    case (screen_q)
      TITLE:   rgb_sel = rgb_title;
      S1:      rgb_sel = rgb_s1;
      D1:      rgb_sel = rgb_d1;
      S2:      rgb_sel = rgb_s2;
      D2:      rgb_sel = rgb_d2;
      CLR:     rgb_sel = rgb_clr;
      default: rgb_sel = 3'b111;
    endcase
  end

  assign rgb       = (blanking_q && !scr_bad) ? 3'b000 : rgb_sel;
  assign key_out   = blanking_q ? 5'd0 : key_pulse;
  assign screen    = screen_q;
  assign stage_rst = stage_rst_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Scoreboard bench for game_screen_ctrl: stimulus queues expected screens, a negedge monitor checks every cycle.
module tb_game_screen_ctrl;
  localparam int BLANK = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic [9:0]  x = 10'd5, y = 10'd1;
  logic [4:0]  key_pulse = 5'h03;
  logic [1:0]  menu_sel = 2'b11, die1_sel = 2'b11, die2_sel = 2'b11;
  logic        dead1 = 1'b0, dead2 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
  logic [2:0]  rgb, screen;
  logic [4:0]  key_out;
  logic        stage_rst;
  logic [11:0] time_left;

  int checks = 0, failures = 0;
  int exp_q[$];
  int rgb_of[6] = '{1, 2, 3, 4, 5, 6};

  game_screen_ctrl #(.BLANK_FRAMES(BLANK), .STAGE_FRAMES(4)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .key_pulse(key_pulse),
    .menu_sel(menu_sel), .die1_sel(die1_sel), .die2_sel(die2_sel),
    .dead1(dead1), .dead2(dead2), .clr1(clr1), .clr2(clr2),
    .rgb_title(3'd1), .rgb_s1(3'd2), .rgb_d1(3'd3), .rgb_s2(3'd4), .rgb_d2(3'd5), .rgb_clr(3'd6),
    .rgb(rgb), .screen(screen), .key_out(key_out), .stage_rst(stage_rst), .time_left(time_left));

  always #5 clk = ~clk;

  // 20-cycle mock frame: x 0..9, y 0..1
  initial forever begin
    @(posedge clk); #1;
    if (x == 10'd9) begin x = 10'd0; y = (y == 10'd1) ? 10'd0 : 10'd1; end
    else x = x + 10'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor
  int  cur_exp = 0, prev_scr = 0, blank_ticks = 0;
  bit  prev_srst = 0, prev_origin = 0;
  always @(negedge clk) begin
    bit tick;
    tick = (x == 10'd0) && (y == 10'd0) && !prev_origin;
    prev_origin = (x == 10'd0) && (y == 10'd0);
    if (rst) begin
      cur_exp = 0; prev_scr = 0; prev_srst = 0; blank_ticks = 0;
    end else begin
      if (int'(screen) != prev_scr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_screen_change", int'(screen), prev_scr);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("screen_change", int'(screen), cur_exp);
        end
        prev_scr = int'(screen);
      end
      if (stage_rst) begin
        chk("blank_rgb", int'(rgb), 0);
        chk("blank_key_out", int'(key_out), 0);
        if (tick) blank_ticks++;
      end else begin
        chk("screen", int'(screen), cur_exp);
        chk("rgb", int'(rgb), rgb_of[cur_exp]);
        chk("key_out", int'(key_out), int'(key_pulse));
      end
      if (prev_srst && !stage_rst) begin
        chk("blank_frames", blank_ticks, BLANK);
        blank_ticks = 0;
      end
      prev_srst = stage_rst;
    end
  end

  task automatic wait_settle(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !stage_rst) return;
    end
    failures++;
    $display("FAIL settle_timeout_%s pending=%0d stage_rst=%0d", nm, exp_q.size(), stage_rst);
    exp_q.delete();
  endtask

  task automatic go(input int dest, input logic [4:0] k, input logic [1:0] ms,
                    input logic [1:0] d1s, input logic [1:0] d2s,
                    input logic dd1, input logic dd2, input logic c1, input logic c2);
    exp_q.push_back(dest);
    @(posedge clk); #1;
    key_pulse = k; menu_sel = ms; die1_sel = d1s; die2_sel = d2s;
    dead1 = dd1; dead2 = dd2; clr1 = c1; clr2 = c2;
    @(posedge clk); #1;
    key_pulse = 5'h03; menu_sel = 2'b11; die1_sel = 2'b11; die2_sel = 2'b11;
    dead1 = 0; dead2 = 0; clr1 = 0; clr2 = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("reset_screen", int'(screen), 0);
    chk("reset_stage_rst", int'(stage_rst), 0);
    chk("reset_rgb", int'(rgb), 1);

    go(1, 5'h03, 2'b00, 2'b11, 2'b11, 0, 0, 0, 0);           // TITLE -> S1
    wait_settle("title_s1");
    go(2, 5'h03, 2'b11, 2'b11, 2'b11, 1, 0, 1, 0);           // dead1 beats clr1
    wait_settle("s1_d1");
    go(0, 5'h03, 2'b11, 2'b01, 2'b11, 0, 0, 0, 0);           // D1 -> TITLE
    wait_settle("d1_title");
    go(1, 5'h03, 2'b00, 2'b11, 2'b11, 0, 0, 0, 0);
    wait_settle("title_s1_b");
    go(2, 5'h03, 2'b11, 2'b11, 2'b11, 1, 0, 0, 0);
    wait_settle("s1_d1_b");
    go(1, 5'h03, 2'b11, 2'b00, 2'b11, 0, 0, 0, 0);           // restart D1 -> S1
    repeat (5) @(posedge clk); #1;
    key_pulse = 5'h1d; die1_sel = 2'b00;                     // ignored while blanking
    @(posedge clk); #1;
    key_pulse = 5'h03; die1_sel = 2'b11;
    wait_settle("d1_s1_restart");
    go(3, 5'h03, 2'b11, 2'b11, 2'b11, 0, 0, 1, 0);           // S1 -> S2
    wait_settle("s1_s2");
    go(4, 5'h03, 2'b11, 2'b11, 2'b11, 0, 1, 0, 0);           // S2 -> D2
    wait_settle("s2_d2");
    go(3, 5'h03, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0);           // D2 -> S2
    wait_settle("d2_s2");
    go(5, 5'h03, 2'b11, 2'b11, 2'b11, 0, 0, 0, 1);           // S2 -> CLR
    wait_settle("s2_clr");
    go(0, 5'h1d, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0);           // CLR -> TITLE
    wait_settle("clr_title");

    // Reset in the middle of a blanking towards S2
    go(1, 5'h03, 2'b00, 2'b11, 2'b11, 0, 0, 0, 0);
    wait_settle("title_s1_c");
    go(3, 5'h03, 2'b11, 2'b11, 2'b11, 0, 0, 1, 0);
    repeat (3) @(posedge clk); #1;
    exp_q.delete();
    rst = 1; #1;
    chk("rst_screen", int'(screen), 0);
    chk("rst_stage_rst", int'(stage_rst), 0);
    chk("rst_rgb", int'(rgb), 1);
    repeat (2) @(posedge clk); #1;
    rst = 0;
    repeat (60) @(posedge clk); #1;
    chk("after_rst_screen", int'(screen), 0);

`ifdef STAGE_TIMER_EN
    go(1, 5'h03, 2'b00, 2'b11, 2'b11, 0, 0, 0, 0);
    wait_settle("t_title_s1");
    go(3, 5'h03, 2'b11, 2'b11, 2'b11, 0, 0, 1, 0);
    wait_settle("t_s1_s2");
    chk("time_left_load", int'(time_left), 4);
    exp_q.push_back(4);                                      // timer expiry kills the player
    for (int k = 3; k >= 0; k--) begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!(x == 10'd0 && y == 10'd0) && n < 40);
      @(posedge clk); #1;
      chk("time_left", int'(time_left), k);
    end
    wait_settle("t_s2_d2");
    chk("timer_death_screen", int'(screen), 4);
`else
    chk("time_left_tied", int'(time_left), 0);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
